dst_ip_filter_table_regs: RTL and testbench

DST_IP_FILTER_TABLE_REGS -- requirements
Module: dst_ip_filter_table_regs

---
 rtl/dst_ip_filter_table_regs_pkg.sv | 28 ++
 rtl/dst_ip_filter_table_regs.sv | 188 ++++++++++++++++++
 tb/tb_dst_ip_filter_table_regs.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dst_ip_filter_table_regs_pkg.sv
// Shared register definitions for the destination-IP filter table register block.
// Holds the filter table depth, the word offsets of the four registers, the
// fixed readback / timeout codes, the default ring tag, and the FSM state type.
package dst_ip_filter_table_regs_pkg;

   // Filter table depth (index width) used across the datapath.
   localparam int FILTER_TABLE_DEPTH_BITS = 5;

   // Word offsets within the block.
   localparam logic [1:0] OFF_ENTRY_IP = 2'd0;
   localparam logic [1:0] OFF_RD_ADDR  = 2'd1;
   localparam logic [1:0] OFF_WR_ADDR  = 2'd2;
   localparam logic [1:0] OFF_UNUSED   = 2'd3;

   // Readback of the unused offset, and reply data when the table never acks.
   localparam logic [31:0] CODE_UNUSED  = 32'hDEADBEEF;
   localparam logic [31:0] CODE_TIMEOUT = 32'hDEAD0001;

   // Default value of reg_addr[22:2] that selects this block.
   localparam logic [20:0] DEFAULT_BLOCK_TAG = 21'h000100;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } filt_state_t;

endpackage

// File: rtl/dst_ip_filter_table_regs.sv
// Register ring slave giving host access to the destination-IP filter table.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reg_*_in                   register ring inputs (req, ack, rd_wr_L, addr, data, src)
//   reg_*_out                  registered register ring outputs, same fields
//   dest_ip_filter_rd_*        table read port: addr/req out, ip/ack in
//   dest_ip_filter_wr_*        table write port: addr/req/ip out, ack in
//
// Ring handshake: a request is a one-cycle pulse with reg_req=1. It is
// answered (or forwarded) exactly once, one cycle later, except for table
// accesses, whose answer is delayed until the table acks or the wait times
// out. An answer to a local request carries reg_ack=1. Table requests are
// level signals held high until the one-cycle ack from the table.
//
// The FSM state is held in the typed register `state` for observation.
module dst_ip_filter_table_regs
   import dst_ip_filter_table_regs_pkg::*;
#(
   parameter int LUT_DEPTH_BITS    = FILTER_TABLE_DEPTH_BITS,
   parameter int REG_ADDR_WIDTH    = 23,
   parameter int BLOCK_ADDR_WIDTH  = 2,
   parameter logic [REG_ADDR_WIDTH-BLOCK_ADDR_WIDTH-1:0] BLOCK_TAG = DEFAULT_BLOCK_TAG,
   parameter int UDP_REG_SRC_WIDTH = 2,
   parameter int TIMEOUT           = 255
) (
   input  logic                         clk,
   input  logic                         reset,

   input  logic                         reg_req_in,
   input  logic                         reg_ack_in,
   input  logic                         reg_rd_wr_L_in,
   input  logic [REG_ADDR_WIDTH-1:0]    reg_addr_in,
   input  logic [31:0]                  reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

   output logic                         reg_req_out,
   output logic                         reg_ack_out,
   output logic                         reg_rd_wr_L_out,
   output logic [REG_ADDR_WIDTH-1:0]    reg_addr_out,
   output logic [31:0]                  reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,

   output logic [LUT_DEPTH_BITS-1:0]    dest_ip_filter_rd_addr,
   output logic                         dest_ip_filter_rd_req,
   input  logic [31:0]                  dest_ip_filter_rd_ip,
   input  logic                         dest_ip_filter_rd_ack,

   output logic [LUT_DEPTH_BITS-1:0]    dest_ip_filter_wr_addr,
   output logic                         dest_ip_filter_wr_req,
   output logic [31:0]                  dest_ip_filter_wr_ip,
   input  logic                         dest_ip_filter_wr_ack
);

   // Sized so the counter can hold TIMEOUT (at least one bit wide).
   localparam int CNT_W = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   filt_state_t                  state;
   logic [CNT_W-1:0]             wait_cnt;
   logic [31:0]                  entry_ip;

   // Request captured while the table access is outstanding.
   logic [REG_ADDR_WIDTH-1:0]    cap_addr;
   logic [31:0]                  cap_data;
   logic [UDP_REG_SRC_WIDTH-1:0] cap_src;

   logic                         is_local;
   logic [BLOCK_ADDR_WIDTH-1:0]  offset;
   logic [31:0]                  rd_mux;

   assign is_local = reg_req_in && !reg_ack_in &&
                     (reg_addr_in[REG_ADDR_WIDTH-1:BLOCK_ADDR_WIDTH] == BLOCK_TAG);
   assign offset   = reg_addr_in[BLOCK_ADDR_WIDTH-1:0];

   assign dest_ip_filter_wr_ip = entry_ip;

   always_comb begin
      rd_mux = CODE_UNUSED;
      case (offset)
         OFF_ENTRY_IP: rd_mux = entry_ip;
         OFF_RD_ADDR:  rd_mux = {{(32-LUT_DEPTH_BITS){1'b0}}, dest_ip_filter_rd_addr};
         OFF_WR_ADDR:  rd_mux = {{(32-LUT_DEPTH_BITS){1'b0}}, dest_ip_filter_wr_addr};
         default:      rd_mux = CODE_UNUSED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_req_out            <= 1'b0;
         reg_ack_out            <= 1'b0;
         reg_rd_wr_L_out        <= 1'b0;
         reg_addr_out           <= '0;
         reg_data_out           <= '0;
         reg_src_out            <= '0;
         dest_ip_filter_rd_addr <= '0;
         dest_ip_filter_rd_req  <= 1'b0;
         dest_ip_filter_wr_addr <= '0;
         dest_ip_filter_wr_req  <= 1'b0;
         entry_ip               <= '0;
         wait_cnt               <= '0;
         cap_addr               <= '0;
         cap_data               <= '0;
         cap_src                <= '0;
         state                  <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (is_local) begin
                  reg_req_out     <= 1'b1;
                  reg_ack_out     <= 1'b1;
                  reg_rd_wr_L_out <= reg_rd_wr_L_in;
                  reg_addr_out    <= reg_addr_in;
                  reg_data_out    <= reg_rd_wr_L_in ? rd_mux : reg_data_in;
                  reg_src_out     <= reg_src_in;
                  if (!reg_rd_wr_L_in) begin
                     case (offset)
                        OFF_ENTRY_IP: entry_ip <= reg_data_in;
                        OFF_RD_ADDR, OFF_WR_ADDR: begin
                           // Hold the reply back until the table answers.
                           reg_req_out     <= 1'b0;
                           reg_ack_out     <= 1'b0;
                           reg_rd_wr_L_out <= 1'b0;
                           reg_addr_out    <= '0;
                           reg_data_out    <= '0;
                           reg_src_out     <= '0;
                           cap_addr        <= reg_addr_in;
                           cap_data        <= reg_data_in;
                           cap_src         <= reg_src_in;
                           wait_cnt        <= '0;
                           if (offset == OFF_RD_ADDR) begin
                              dest_ip_filter_rd_addr <= reg_data_in[LUT_DEPTH_BITS-1:0];
                              dest_ip_filter_rd_req  <= 1'b1;
                              state                  <= ST_RD_WAIT;
                           end else begin
                              dest_ip_filter_wr_addr <= reg_data_in[LUT_DEPTH_BITS-1:0];
                              dest_ip_filter_wr_req  <= 1'b1;
                              state                  <= ST_WR_WAIT;
                           end
                        end
                        default: ; // unused offset: write has no effect
                     endcase
                  end
               end else begin
                  reg_req_out     <= reg_req_in;
                  reg_ack_out     <= reg_ack_in;
                  reg_rd_wr_L_out <= reg_rd_wr_L_in;
                  reg_addr_out    <= reg_addr_in;
                  reg_data_out    <= reg_data_in;
                  reg_src_out     <= reg_src_in;
               end
            end

            ST_RD_WAIT, ST_WR_WAIT: begin
               // Anything arriving on the ring while waiting is dropped.
               reg_req_out     <= 1'b0;
               reg_ack_out     <= 1'b0;
               reg_rd_wr_L_out <= 1'b0;
               reg_addr_out    <= '0;
               reg_data_out    <= '0;
               reg_src_out     <= '0;
               // Ack is checked before the timeout so a same-cycle ack wins.
               if ((state == ST_RD_WAIT && dest_ip_filter_rd_ack) ||
                   (state == ST_WR_WAIT && dest_ip_filter_wr_ack) ||
                   (wait_cnt == TIMEOUT_CNT)) begin
                  reg_req_out           <= 1'b1;
                  reg_ack_out           <= 1'b1;
                  reg_addr_out          <= cap_addr;
                  reg_src_out           <= cap_src;
                  reg_data_out          <= cap_data;
                  dest_ip_filter_rd_req <= 1'b0;
                  dest_ip_filter_wr_req <= 1'b0;
                  state                 <= ST_IDLE;
                  if (state == ST_RD_WAIT && dest_ip_filter_rd_ack)
                     entry_ip <= dest_ip_filter_rd_ip;
                  else if (!(state == ST_WR_WAIT && dest_ip_filter_wr_ack))
                     reg_data_out <= CODE_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dst_ip_filter_table_regs.sv
module tb_dst_ip_filter_table_regs;
   import dst_ip_filter_table_regs_pkg::*;

   localparam logic [20:0] TAG     = 21'h000100;
   localparam int          TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
   logic [22:0] reg_addr_in = '0;
   logic [31:0] reg_data_in = '0;
   logic [1:0]  reg_src_in = '0;
   logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
   logic [22:0] reg_addr_out;
   logic [31:0] reg_data_out;
   logic [1:0]  reg_src_out;
   logic [4:0]  rd_addr, wr_addr;
   logic        rd_req, wr_req;
   logic [31:0] rd_ip = '0;
   logic        rd_ack = 1'b0;
   logic [31:0] wr_ip;
   logic        wr_ack = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];

   dst_ip_filter_table_regs dut (
      .clk(clk), .reset(reset),
      .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
      .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
      .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
      .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
      .dest_ip_filter_rd_addr(rd_addr), .dest_ip_filter_rd_req(rd_req),
      .dest_ip_filter_rd_ip(rd_ip), .dest_ip_filter_rd_ack(rd_ack),
      .dest_ip_filter_wr_addr(wr_addr), .dest_ip_filter_wr_req(wr_req),
      .dest_ip_filter_wr_ip(wr_ip), .dest_ip_filter_wr_ack(wr_ack)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk_reply(input logic ack, input logic rdwr, input logic [22:0] addr,
                                            input logic [31:0] data, input logic [1:0] src);
      return {4'b0, 1'b1, ack, rdwr, addr, data, src};
   endfunction

   // Scoreboard: every reply on the ring must match the head of exp_q.
   always @(negedge clk) begin
      if (!reset && reg_req_out) begin
         if (exp_q.size() == 0)
            check_eq("unexpected_reply",
                     {4'b0, reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out},
                     64'h0);
         else
            check_eq("reply",
                     {4'b0, reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out},
                     exp_q.pop_front());
      end
   end

   // ---------------- drivers ----------------
   // Drives a one-cycle ring request; returns 1 time unit after the edge that sampled it.
   task automatic drive_req(input logic rd, input logic ack, input logic [20:0] tag, input logic [1:0] off,
                            input logic [31:0] data, input logic [1:0] src);
      reg_req_in = 1'b1; reg_ack_in = ack; reg_rd_wr_L_in = rd;
      reg_addr_in = {tag, off}; reg_data_in = data; reg_src_in = src;
      @(posedge clk); #1;
      reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
      reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
   endtask

   // Local access whose reply is expected with the given data.
   task automatic local_acc(input logic rd, input logic [1:0] off, input logic [31:0] data,
                            input logic [31:0] exp_data);
      logic [1:0] src;
      src = 2'($urandom_range(0, 3));
      exp_q.push_back(mk_reply(1'b1, rd, {TAG, off}, exp_data, src));
      drive_req(rd, 1'b0, TAG, off, data, src);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'h0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_req_out", {63'b0, reg_req_out}, 64'h0);
      check_eq("rst_ack_out", {63'b0, reg_ack_out}, 64'h0);
      check_eq("rst_data_out", {32'b0, reg_data_out}, 64'h0);
      check_eq("rst_table_reqs", {62'b0, rd_req, wr_req}, 64'h0);
      check_eq("rst_addrs", {54'b0, rd_addr, wr_addr}, 64'h0);
      check_eq("rst_wr_ip", {32'b0, wr_ip}, 64'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Table write of ENTRY_IP, ack returned after 2 cycles.
      local_acc(1'b0, OFF_ENTRY_IP, 32'hC0A80001, 32'hC0A80001);
      drain();
      local_acc(1'b0, OFF_WR_ADDR, 32'd3, 32'd3);
      check_eq("wr_req_c1", {63'b0, wr_req}, 64'h1);
      check_eq("wr_addr", {59'b0, wr_addr}, 64'd3);
      check_eq("wr_ip", {32'b0, wr_ip}, 64'hC0A80001);
      check_eq("no_rd_req_in_wr", {63'b0, rd_req}, 64'h0);
      @(posedge clk); #1;
      check_eq("wr_req_c2", {63'b0, wr_req}, 64'h1);
      wr_ack = 1'b1;
      @(posedge clk); #1;
      wr_ack = 1'b0;
      check_eq("wr_req_dropped", {63'b0, wr_req}, 64'h0);
      drain();

      // Table read, ack after 4 cycles, then readback of ENTRY_IP.
      local_acc(1'b0, OFF_RD_ADDR, 32'd7, 32'd7);
      check_eq("rd_req_high", {63'b0, rd_req}, 64'h1);
      check_eq("rd_addr", {59'b0, rd_addr}, 64'd7);
      check_eq("no_wr_req_in_rd", {63'b0, wr_req}, 64'h0);
      repeat (3) @(posedge clk);
      #1;
      rd_ack = 1'b1; rd_ip = 32'h0A000002;
      @(posedge clk); #1;
      rd_ack = 1'b0; rd_ip = '0;
      check_eq("rd_req_dropped", {63'b0, rd_req}, 64'h0);
      drain();
      local_acc(1'b1, OFF_ENTRY_IP, 32'h0, 32'h0A000002);
      drain();

      // Non-local traffic forwarded unchanged; acked requests are never local.
      for (int i = 0; i < 6; i++) begin
         logic [20:0] t;
         logic [31:0] d;
         logic [1:0]  s;
         logic        r, a;
         t = (i == 0) ? 21'h000200 : 21'($urandom);
         if (i == 5) t = TAG;
         if (t == TAG && i != 5) t = t ^ 21'h1;
         d = (i == 0) ? 32'h12345678 : $urandom;
         s = 2'($urandom_range(0, 3));
         r = 1'($urandom_range(0, 1));
         a = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
         exp_q.push_back(mk_reply(a, r, {t, 2'(i)}, d, s));
         drive_req(r, a, t, 2'(i), d, s);
         check_eq("fwd_table_idle", {62'b0, rd_req, wr_req}, 64'h0);
      end
      drain();

      // Timeout: no rd_ack; a dropped local request and a stray wr_ack meanwhile.
      // The counter runs 0..TIMEOUT, so rd_req stays high TIMEOUT+1 cycles.
      local_acc(1'b0, OFF_RD_ADDR, 32'd9, CODE_TIMEOUT);
      cnt = 0;
      while (rd_req && cnt < 400) begin
         cnt++;
         if (cnt == 10) begin
            reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b1; reg_addr_in = {TAG, OFF_UNUSED};
         end
         if (cnt == 11) begin
            reg_req_in = 1'b0; reg_rd_wr_L_in = 1'b0; reg_addr_in = '0; wr_ack = 1'b1;
         end
         if (cnt == 12) wr_ack = 1'b0;
         @(posedge clk); #1;
      end
      check_eq("timeout_cycles", 64'(cnt), 64'(TIMEOUT + 1));
      check_eq("timeout_rd_req", {63'b0, rd_req}, 64'h0);
      drain();
      local_acc(1'b1, OFF_ENTRY_IP, 32'h0, 32'h0A000002);
      drain();

      // Ack in the very cycle the counter reaches TIMEOUT: the ack wins.
      local_acc(1'b0, OFF_RD_ADDR, 32'd9, 32'd9);
      repeat (TIMEOUT) @(posedge clk);
      #1;
      rd_ack = 1'b1; rd_ip = 32'h55AA1234;
      @(posedge clk); #1;
      rd_ack = 1'b0; rd_ip = '0;
      check_eq("ackwin_rd_req", {63'b0, rd_req}, 64'h0);
      drain();
      local_acc(1'b1, OFF_ENTRY_IP, 32'h0, 32'h55AA1234);
      drain();

      // Reset during the 2nd cycle of WR_WAIT: no reply, WR_ADDR cleared.
      drive_req(1'b0, 1'b0, TAG, OFF_WR_ADDR, 32'd6, 2'd1);
      check_eq("wr_req_before_rst", {63'b0, wr_req}, 64'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_wait_wr_req", {63'b0, wr_req}, 64'h0);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      local_acc(1'b1, OFF_WR_ADDR, 32'h0, 32'h0);
      drain();

      // Unused offset and index truncation.
      local_acc(1'b1, OFF_UNUSED, 32'h0, CODE_UNUSED);
      local_acc(1'b0, OFF_UNUSED, 32'h11111111, 32'h11111111);
      drain();
      local_acc(1'b1, OFF_UNUSED, 32'h0, CODE_UNUSED);
      drain();
      local_acc(1'b0, OFF_RD_ADDR, 32'd37, 32'd37);
      check_eq("rd_addr_trunc", {59'b0, rd_addr}, 64'd5);
      rd_ack = 1'b1; rd_ip = 32'hFEEDF00D;
      @(posedge clk); #1;
      rd_ack = 1'b0; rd_ip = '0;
      drain();
      local_acc(1'b1, OFF_RD_ADDR, 32'h0, 32'd5);
      drain();
      local_acc(1'b1, OFF_ENTRY_IP, 32'h0, 32'hFEEDF00D);
      drain();

      check_eq("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
